exu_lsu: RTL and testbench
==========================

# exu_lsu

Load/store unit sitting directly downstream of the EXU address-generation stage. It accepts one memory request per transaction (read/write enables, ALU-computed address, store data, access size), checks alignment, drives a single-outstanding-transaction data bus with byte strobes, then sign- or zero-extends load data and presents it for register writeback. It is blocking: a new request is accepted only after the previous one has fully completed.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width (only 32 supported)

Ports:
- i_clk  in  1  sole clock
- i_rst  in  1  asynchronous, active-high reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  LSU idle, can accept
- i_mem_ren  in  1  load request
- i_mem_wen  in  1  store request (wins if both set)
- i_mem_addr  in  AW  byte address from AGU
- i_mem_wdata  in  DW  store data, LSB-aligned
- i_funct3  in  3  RV32 size/sign code
- i_rd_idx  in  5  load destination register
- o_bus_valid  out  1  bus address phase valid
- i_bus_ready  in  1  bus accepts address phase
- o_bus_addr  out  AW  word-aligned address ({addr[31:2],2'b00})
- o_bus_wen  out  1  write transaction
- o_bus_wstrb  out  4  byte strobes
- o_bus_wdata  out  DW  lane-replicated store data
- i_bus_rvalid  in  1  response (load data or store ack)
- i_bus_rdata  in  DW  load data word
- o_wb_valid  out  1  one-cycle load writeback pulse
- o_wb_rd  out  5  writeback register
- o_wb_data  out  DW  extended load data
- o_misalign  out  1  one-cycle misaligned-access pulse
- o_misalign_addr  out  AW  faulting byte address
- o_misalign_st  out  1  fault was a store

## Operation
- States: IDLE, REQ, RSP, DONE.
- IDLE: o_req_ready=1. On i_req_valid & (ren|wen): latch addr, wdata, funct3, rd, store flag. If misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> DONE with misalign flag; else -> REQ. Request with neither enable: accepted, discarded, stays IDLE.
- REQ: o_bus_valid=1, address/wen/wstrb/wdata stable from latched values. On i_bus_ready -> RSP.
- RSP: wait for i_bus_rvalid; capture extended rdata -> DONE. rvalid outside RSP ignored.
- DONE: load -> o_wb_valid=1; misalign -> o_misalign=1; store -> no pulse. Always -> IDLE next cycle.
- funct3 loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Other codes treated as word.
- wstrb: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; loads 4'b0000.
- wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as-is.
- Load extract: shift rdata right by addr[1:0]*8, take byte/half, sign-extend (LB/LH) or zero-extend (LBU/LHU).

## Timing
- Reset: state IDLE; o_req_ready=1; o_bus_valid, o_bus_wen, o_wb_valid, o_misalign, o_misalign_st=0; o_bus_addr, o_bus_wstrb, o_bus_wdata, o_wb_rd, o_wb_data, o_misalign_addr=0.
- Accept at cycle 0 -> o_bus_valid from cycle 1 until handshake cycle inclusive.
- Zero-wait bus (ready cycle 1, rvalid cycle 2) -> o_wb_valid cycle 3, o_req_ready high cycle 4. Minimum 4 cycles per access.
- Misaligned: accept cycle 0 -> o_misalign cycle 1, o_bus_valid never asserted.
- o_req_ready is purely state==IDLE; no combinational path from i_req_valid.
- Reset mid-transaction: returns to IDLE immediately, drops transaction, no wb/misalign pulse; bus slave responsibility to also reset.

## Structure
- Package lsu_pkg: funct3 load/store constants, state encoding, size enum (BYTE/HALF/WORD).
- Sub-module lsu_align (combinational): produces wstrb, replicated wdata, misaligned flag, and extended load data from addr[1:0], funct3, raw data; instantiated once in exu_lsu.

## Test plan
- SW addr 0x100 data 0xDEADBEEF, zero-wait bus -> bus addr 0x100, wstrb 1111, wdata 0xDEADBEEF, no wb pulse, ready at cycle 4.
- SB addr 0x103 data 0x000000A5 -> addr 0x100, wstrb 1000, wdata 0xA5A5A5A5.
- LB addr 0x102, rdata 0x12F03456 -> o_wb_data 0xFFFFFFF0, rd echoed; LBU same -> 0x000000F0; LHU addr 0x102 -> 0x000012F0.
- LW addr 0x101 -> o_misalign=1, addr 0x101, st=0, no o_bus_valid; SH addr 0x203 -> st=1.
- LW with i_bus_ready low 3 cycles and rvalid delayed 2 -> o_bus_valid/addr stable throughout, o_req_ready low, single wb pulse.
- Assert i_rst while in RSP -> all outputs reset values, no wb pulse, late rvalid ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the EXU load/store unit: funct3 codes, FSM state
// encoding and the access-size decode used by the alignment logic.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // Unsigned-load codes have no store counterpart, so stores fall back to word.
    function automatic size_e size_of(input logic [2:0] f3, input logic is_store);
        size_e sz;
        case (f3)
            F3_LB:   sz = SZ_BYTE;
            F3_LH:   sz = SZ_HALF;
            F3_LBU:  sz = is_store ? SZ_WORD : SZ_BYTE;
            F3_LHU:  sz = is_store ? SZ_WORD : SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store strobes and lane replication,
// misalignment detection and load data extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic        misalign,
    output logic [31:0] rdata_ext
);

    size_e       size_s;
    logic [31:0] shifted_s;

    // Decode size, then steer lanes for both directions.
    always_comb begin
        size_s    = size_of(funct3, is_store);
        shifted_s = rdata >> {addr_lo, 3'b000};
        wstrb     = 4'b0000;
        wdata_rep = wdata;
        misalign  = 1'b0;
        rdata_ext = shifted_s;
        case (size_s)
            SZ_BYTE: begin
                wstrb     = is_store ? (4'b0001 << addr_lo) : 4'b0000;
                wdata_rep = {4{wdata[7:0]}};
                misalign  = 1'b0;
                rdata_ext = funct3[2] ? {24'h000000, shifted_s[7:0]}
                                      : {{24{shifted_s[7]}}, shifted_s[7:0]};
            end
            SZ_HALF: begin
                wstrb     = is_store ? (4'b0011 << addr_lo) : 4'b0000;
                wdata_rep = {2{wdata[15:0]}};
                misalign  = addr_lo[0];
                rdata_ext = funct3[2] ? {16'h0000, shifted_s[15:0]}
                                      : {{16{shifted_s[15]}}, shifted_s[15:0]};
            end
            SZ_WORD: begin
                wstrb     = is_store ? 4'b1111 : 4'b0000;
                wdata_rep = wdata;
                misalign  = (addr_lo != 2'b00);
                rdata_ext = shifted_s;
            end
            default: begin
                wstrb     = 4'b0000;
                wdata_rep = wdata;
                misalign  = 1'b0;
                rdata_ext = shifted_s;
            end
        endcase
    end

endmodule

// File: rtl/exu_lsu.sv
// Blocking single-outstanding load/store unit between the EXU AGU stage and
// the data bus; all outputs are registered.
module exu_lsu
    import lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_mem_ren,
    input  logic          i_mem_wen,
    input  logic [AW-1:0] i_mem_addr,
    input  logic [DW-1:0] i_mem_wdata,
    input  logic [2:0]    i_funct3,
    input  logic [4:0]    i_rd_idx,
    output logic          o_bus_valid,
    input  logic          i_bus_ready,
    output logic [AW-1:0] o_bus_addr,
    output logic          o_bus_wen,
    output logic [3:0]    o_bus_wstrb,
    output logic [DW-1:0] o_bus_wdata,
    input  logic          i_bus_rvalid,
    input  logic [DW-1:0] i_bus_rdata,
    output logic          o_wb_valid,
    output logic [4:0]    o_wb_rd,
    output logic [DW-1:0] o_wb_data,
    output logic          o_misalign,
    output logic [AW-1:0] o_misalign_addr,
    output logic          o_misalign_st
);

    logic [1:0]    state_r;
    logic [1:0]    addr_lo_r;
    logic [2:0]    funct3_r;
    logic [4:0]    rd_r;
    logic          store_r;
    logic          req_ready_r;
    logic          bus_valid_r;
    logic [AW-1:0] bus_addr_r;
    logic          bus_wen_r;
    logic [3:0]    bus_wstrb_r;
    logic [DW-1:0] bus_wdata_r;
    logic          wb_valid_r;
    logic [DW-1:0] wb_data_r;
    logic          misalign_r;
    logic [AW-1:0] misalign_addr_r;
    logic          misalign_st_r;

    logic [1:0]    al_addr_lo_s;
    logic [2:0]    al_funct3_s;
    logic          al_store_s;
    logic [3:0]    wstrb_s;
    logic [DW-1:0] wdata_rep_s;
    logic          misalign_s;
    logic [DW-1:0] rdata_ext_s;
    logic          accept_s;

    // The aligner sees the incoming request while idle, the latched one otherwise.
    always_comb begin
        accept_s = i_req_valid && (i_mem_ren || i_mem_wen);
        if (state_r == ST_IDLE) begin
            al_addr_lo_s = i_mem_addr[1:0];
            al_funct3_s  = i_funct3;
            al_store_s   = i_mem_wen;
        end else begin
            al_addr_lo_s = addr_lo_r;
            al_funct3_s  = funct3_r;
            al_store_s   = store_r;
        end
    end

    lsu_align u_align (
        .addr_lo   (al_addr_lo_s),
        .funct3    (al_funct3_s),
        .is_store  (al_store_s),
        .wdata     (i_mem_wdata),
        .rdata     (i_bus_rdata),
        .wstrb     (wstrb_s),
        .wdata_rep (wdata_rep_s),
        .misalign  (misalign_s),
        .rdata_ext (rdata_ext_s)
    );

    // Transaction FSM with registered bus, writeback and fault outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r         <= ST_IDLE;
            addr_lo_r       <= 2'b00;
            funct3_r        <= 3'b000;
            rd_r            <= 5'd0;
            store_r         <= 1'b0;
            req_ready_r     <= 1'b1;
            bus_valid_r     <= 1'b0;
            bus_addr_r      <= '0;
            bus_wen_r       <= 1'b0;
            bus_wstrb_r     <= 4'b0000;
            bus_wdata_r     <= '0;
            wb_valid_r      <= 1'b0;
            wb_data_r       <= '0;
            misalign_r      <= 1'b0;
            misalign_addr_r <= '0;
            misalign_st_r   <= 1'b0;
        end else begin
            wb_valid_r <= 1'b0;
            misalign_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        addr_lo_r   <= i_mem_addr[1:0];
                        funct3_r    <= i_funct3;
                        rd_r        <= i_rd_idx;
                        store_r     <= i_mem_wen;
                        req_ready_r <= 1'b0;
                        if (misalign_s) begin
                            state_r         <= ST_DONE;
                            misalign_r      <= 1'b1;
                            misalign_addr_r <= i_mem_addr;
                            misalign_st_r   <= i_mem_wen;
                        end else begin
                            state_r     <= ST_REQ;
                            bus_valid_r <= 1'b1;
                            bus_addr_r  <= {i_mem_addr[AW-1:2], 2'b00};
                            bus_wen_r   <= i_mem_wen;
                            bus_wstrb_r <= wstrb_s;
                            bus_wdata_r <= wdata_rep_s;
                        end
                    end
                end
                ST_REQ: begin
                    if (i_bus_ready) begin
                        bus_valid_r <= 1'b0;
                        state_r     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (i_bus_rvalid) begin
                        state_r <= ST_DONE;
                        if (!store_r) begin
                            wb_valid_r <= 1'b1;
                            wb_data_r  <= rdata_ext_s;
                        end
                    end
                end
                ST_DONE: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b1;
                    bus_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready     = req_ready_r;
    assign o_bus_valid     = bus_valid_r;
    assign o_bus_addr      = bus_addr_r;
    assign o_bus_wen       = bus_wen_r;
    assign o_bus_wstrb     = bus_wstrb_r;
    assign o_bus_wdata     = bus_wdata_r;
    assign o_wb_valid      = wb_valid_r;
    assign o_wb_rd         = rd_r;
    assign o_wb_data       = wb_data_r;
    assign o_misalign      = misalign_r;
    assign o_misalign_addr = misalign_addr_r;
    assign o_misalign_st   = misalign_st_r;

endmodule

// File: tb/tb_exu_lsu.sv
// Directed self-checking bench for exu_lsu with a simple scripted bus slave.
module tb_exu_lsu;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_mem_ren;
    logic        i_mem_wen;
    logic [31:0] i_mem_addr;
    logic [31:0] i_mem_wdata;
    logic [2:0]  i_funct3;
    logic [4:0]  i_rd_idx;
    logic        o_bus_valid;
    logic        i_bus_ready;
    logic [31:0] o_bus_addr;
    logic        o_bus_wen;
    logic [3:0]  o_bus_wstrb;
    logic [31:0] o_bus_wdata;
    logic        i_bus_rvalid;
    logic [31:0] i_bus_rdata;
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_misalign;
    logic [31:0] o_misalign_addr;
    logic        o_misalign_st;

    int n_asrt = 0;
    int n_fail = 0;

    // Results captured by run_op
    int          r_ready0;
    int          r_bus_cycles;
    int          r_unstable;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic        r_wen;
    int          r_wb_cnt;
    logic [31:0] r_wb_data;
    logic [4:0]  r_wb_rd;
    int          r_mis_cnt;
    int          r_mis_cycle;
    logic [31:0] r_mis_addr;
    logic        r_mis_st;
    int          r_ready_cycle;

    exu_lsu #(.AW(32), .DW(32)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_mem_ren       (i_mem_ren),
        .i_mem_wen       (i_mem_wen),
        .i_mem_addr      (i_mem_addr),
        .i_mem_wdata     (i_mem_wdata),
        .i_funct3        (i_funct3),
        .i_rd_idx        (i_rd_idx),
        .o_bus_valid     (o_bus_valid),
        .i_bus_ready     (i_bus_ready),
        .o_bus_addr      (o_bus_addr),
        .o_bus_wen       (o_bus_wen),
        .o_bus_wstrb     (o_bus_wstrb),
        .o_bus_wdata     (o_bus_wdata),
        .i_bus_rvalid    (i_bus_rvalid),
        .i_bus_rdata     (i_bus_rdata),
        .o_wb_valid      (o_wb_valid),
        .o_wb_rd         (o_wb_rd),
        .o_wb_data       (o_wb_data),
        .o_misalign      (o_misalign),
        .o_misalign_addr (o_misalign_addr),
        .o_misalign_st   (o_misalign_st)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request (cycle 0) and play the bus slave until the LSU is idle again.
    task automatic run_op(input logic wen, input logic ren, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] rdata, input int rdy_wait, input int rv_wait);
        int c;
        int rw;
        int hs;
        bit rv_done;
        rw = 0; hs = -1; rv_done = 1'b0;
        r_bus_cycles = 0; r_unstable = 0; r_wb_cnt = 0; r_mis_cnt = 0;
        r_mis_cycle = -1; r_ready_cycle = -1;
        r_bus_addr = 32'h0; r_wstrb = 4'h0; r_wdata = 32'h0; r_wen = 1'b0;
        r_wb_data = 32'h0; r_wb_rd = 5'd0; r_mis_addr = 32'h0; r_mis_st = 1'b0;
        @(negedge i_clk);
        r_ready0    = int'(o_req_ready);
        i_req_valid = 1'b1; i_mem_wen = wen; i_mem_ren = ren; i_mem_addr = addr;
        i_mem_wdata = wdata; i_funct3 = f3; i_rd_idx = rd;
        @(negedge i_clk);
        i_req_valid = 1'b0; i_mem_wen = 1'b0; i_mem_ren = 1'b0;
        for (c = 1; c < 40; c++) begin
            if (o_bus_valid) begin
                if (r_bus_cycles == 0) begin
                    r_bus_addr = o_bus_addr; r_wstrb = o_bus_wstrb;
                    r_wdata = o_bus_wdata; r_wen = o_bus_wen;
                end else if (o_bus_addr !== r_bus_addr || o_bus_wstrb !== r_wstrb ||
                             o_bus_wdata !== r_wdata || o_bus_wen !== r_wen) begin
                    r_unstable++;
                end
                r_bus_cycles++;
            end
            if (o_wb_valid) begin
                r_wb_cnt++; r_wb_data = o_wb_data; r_wb_rd = o_wb_rd;
            end
            if (o_misalign) begin
                r_mis_cnt++; r_mis_cycle = c; r_mis_addr = o_misalign_addr; r_mis_st = o_misalign_st;
            end
            if (o_req_ready) begin
                r_ready_cycle = c;
                break;
            end
            i_bus_ready = 1'b0; i_bus_rvalid = 1'b0;
            if (o_bus_valid) begin
                if (rw >= rdy_wait) begin
                    i_bus_ready = 1'b1; hs = c;
                end else begin
                    rw++;
                end
            end else if (hs >= 0 && !rv_done && c >= hs + 1 + rv_wait) begin
                i_bus_rvalid = 1'b1; i_bus_rdata = rdata; rv_done = 1'b1;
            end
            @(negedge i_clk);
        end
        i_bus_ready = 1'b0; i_bus_rvalid = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_req_valid = 1'b0; i_mem_ren = 1'b0; i_mem_wen = 1'b0;
        i_mem_addr = 32'h0; i_mem_wdata = 32'h0; i_funct3 = 3'b000; i_rd_idx = 5'd0;
        i_bus_ready = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = 32'h0;
        @(negedge i_clk); @(negedge i_clk);
        chk("rst_ready", {31'd0, o_req_ready}, 32'd1);
        chk("rst_bus_valid", {31'd0, o_bus_valid}, 32'd0);
        chk("rst_wb_valid", {31'd0, o_wb_valid}, 32'd0);
        chk("rst_misalign", {31'd0, o_misalign}, 32'd0);
        chk("rst_bus_addr", o_bus_addr, 32'h0);
        chk("rst_wb_data", o_wb_data, 32'h0);
        i_rst = 1'b0;

        // SW 0x100, zero-wait bus
        run_op(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 3'b010, 5'd3, 32'h0, 0, 0);
        chk("sw_ready0", r_ready0, 32'd1);
        chk("sw_addr", r_bus_addr, 32'h100);
        chk("sw_wstrb", {28'd0, r_wstrb}, 32'hF);
        chk("sw_wdata", r_wdata, 32'hDEADBEEF);
        chk("sw_wen", {31'd0, r_wen}, 32'd1);
        chk("sw_bus_cycles", r_bus_cycles, 32'd1);
        chk("sw_wb_cnt", r_wb_cnt, 32'd0);
        chk("sw_ready_cycle", r_ready_cycle, 32'd4);

        // SB 0x103
        run_op(1'b1, 1'b0, 32'h103, 32'h000000A5, 3'b000, 5'd0, 32'h0, 0, 0);
        chk("sb_addr", r_bus_addr, 32'h100);
        chk("sb_wstrb", {28'd0, r_wstrb}, 32'h8);
        chk("sb_wdata", r_wdata, 32'hA5A5A5A5);

        // LB / LBU / LHU at 0x102
        run_op(1'b0, 1'b1, 32'h102, 32'h0, 3'b000, 5'd9, 32'h12F03456, 0, 0);
        chk("lb_wen", {31'd0, r_wen}, 32'd0);
        chk("lb_wstrb", {28'd0, r_wstrb}, 32'h0);
        chk("lb_wb_cnt", r_wb_cnt, 32'd1);
        chk("lb_data", r_wb_data, 32'hFFFFFFF0);
        chk("lb_rd", {27'd0, r_wb_rd}, 32'd9);
        chk("lb_ready_cycle", r_ready_cycle, 32'd4);
        run_op(1'b0, 1'b1, 32'h102, 32'h0, 3'b100, 5'd10, 32'h12F03456, 0, 0);
        chk("lbu_data", r_wb_data, 32'h000000F0);
        chk("lbu_rd", {27'd0, r_wb_rd}, 32'd10);
        run_op(1'b0, 1'b1, 32'h102, 32'h0, 3'b101, 5'd11, 32'h12F03456, 0, 0);
        chk("lhu_data", r_wb_data, 32'h000012F0);
        run_op(1'b0, 1'b1, 32'h100, 32'h0, 3'b001, 5'd12, 32'h00008001, 0, 0);
        chk("lh_data", r_wb_data, 32'hFFFF8001);

        // Misaligned LW and SH
        run_op(1'b0, 1'b1, 32'h101, 32'h0, 3'b010, 5'd4, 32'h0, 0, 0);
        chk("lw_mis_cnt", r_mis_cnt, 32'd1);
        chk("lw_mis_cycle", r_mis_cycle, 32'd1);
        chk("lw_mis_addr", r_mis_addr, 32'h101);
        chk("lw_mis_st", {31'd0, r_mis_st}, 32'd0);
        chk("lw_mis_bus", r_bus_cycles, 32'd0);
        chk("lw_mis_wb", r_wb_cnt, 32'd0);
        run_op(1'b1, 1'b0, 32'h203, 32'h1234, 3'b001, 5'd0, 32'h0, 0, 0);
        chk("sh_mis_addr", r_mis_addr, 32'h203);
        chk("sh_mis_st", {31'd0, r_mis_st}, 32'd1);
        chk("sh_mis_bus", r_bus_cycles, 32'd0);

        // Request with no enable is dropped
        run_op(1'b0, 1'b0, 32'h400, 32'h0, 3'b010, 5'd1, 32'h0, 0, 0);
        chk("nop_ready_cycle", r_ready_cycle, 32'd1);
        chk("nop_bus", r_bus_cycles, 32'd0);

        // LW with bus stalls
        run_op(1'b0, 1'b1, 32'h200, 32'h0, 3'b010, 5'd17, 32'hCAFEF00D, 3, 2);
        chk("lws_bus_cycles", r_bus_cycles, 32'd4);
        chk("lws_unstable", r_unstable, 32'd0);
        chk("lws_addr", r_bus_addr, 32'h200);
        chk("lws_wb_cnt", r_wb_cnt, 32'd1);
        chk("lws_data", r_wb_data, 32'hCAFEF00D);
        chk("lws_rd", {27'd0, r_wb_rd}, 32'd17);
        chk("lws_ready_cycle", r_ready_cycle, 32'd9);

        // Reset while waiting for the response
        @(negedge i_clk);
        i_req_valid = 1'b1; i_mem_ren = 1'b1; i_mem_addr = 32'h300; i_funct3 = 3'b010; i_rd_idx = 5'd7;
        @(negedge i_clk);
        i_req_valid = 1'b0; i_mem_ren = 1'b0;
        chk("rr_bus_valid", {31'd0, o_bus_valid}, 32'd1);
        i_bus_ready = 1'b1;
        @(negedge i_clk);
        i_bus_ready = 1'b0;
        chk("rr_in_rsp", {31'd0, o_bus_valid}, 32'd0);
        i_rst = 1'b1;
        #1;
        chk("rr_ready", {31'd0, o_req_ready}, 32'd1);
        chk("rr_bus_addr", o_bus_addr, 32'h0);
        chk("rr_bus_wdata", o_bus_wdata, 32'h0);
        chk("rr_wb_data", o_wb_data, 32'h0);
        chk("rr_wb_rd", {27'd0, o_wb_rd}, 32'd0);
        chk("rr_mis_addr", o_misalign_addr, 32'h0);
        chk("rr_mis_st", {31'd0, o_misalign_st}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        i_bus_rvalid = 1'b1; i_bus_rdata = 32'h55AA55AA;
        @(negedge i_clk);
        i_bus_rvalid = 1'b0;
        chk("rr_late_wb", {31'd0, o_wb_valid}, 32'd0);
        @(negedge i_clk);
        chk("rr_late_wb2", {31'd0, o_wb_valid}, 32'd0);
        chk("rr_late_data", o_wb_data, 32'h0);
        chk("rr_idle", {31'd0, o_req_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
